idex_hazard_ctrl: RTL and testbench

//  Reader-side controller of the ID/EX pipeline register in the 5-stage core. Watches the EX-stage

---
 rtl/idex_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_idex_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// idex_hazard_ctrl
//
// Reader-side controller of the ID/EX pipeline register in a 5-stage core.
// Compares the EX-stage destination held in ID/EX against the ID-stage
// sources to detect load-use hazards. It also reacts to EX branch resolution
// and to MEM-stage back-pressure. From these it drives the PC, IF/ID and ID/EX
// write enables and the flush/bubble controls.
//
// A 3-state FSM (RUN, LOAD_STALL, FLUSH) and a small down-counter stretch
// load-use stalls to LOAD_LAT cycles and branch flushes to FLUSH_CYCLES
// cycles. The control outputs are combinational from the registered state and
// the current inputs.
//
// Parameters
//   LOAD_LAT      bubble cycles per load-use hazard (1..7)
//   FLUSH_CYCLES  flush/bubble cycles per taken branch (1..7)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk              in   clock, all state on rising edge
//   reset            in   synchronous, active-high
//   ifid_rs1/rs2     in   ID-stage source registers
//   ifid_uses_rs1/2  in   ID instruction actually reads rs1/rs2
//   idex_rd          in   destination register held in ID/EX
//   idex_mem_read    in   MemoryRead control held in ID/EX
//   ex_branch_taken  in   EX resolved a taken branch/jump this cycle
//   mem_busy         in   MEM stage cannot accept; freeze the pipeline
//   pc_write         out  PC updates this edge
//   ifid_write       out  IF/ID latches this edge
//   idex_write       out  ID/EX latches this edge
//   ifid_flush       out  IF/ID loads a NOP
//   idex_bubble      out  ID/EX loads zero control fields
//   state            out  0=RUN 1=LOAD_STALL 2=FLUSH
//   stall_count      out  cycles with pc_write=0, saturating
//   flush_count      out  taken-branch flush events, saturating
// -----------------------------------------------------------------------------
module idex_hazard_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  logic       flush_event;

  assign state = state_q;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign hazard = idex_mem_read && (idex_rd != 5'd0) &&
                  ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_event = 1'b0;

    if (reset) begin
      // Idle outputs while reset is held; the sequential block clears state.
    end else if (mem_busy) begin
      // Freeze everything. State and counter hold, so the pending branch or
      // load in EX is handled again once MEM releases.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_event = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_RELOAD;
            end
          end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            // The injected bubble clears idex_mem_read next cycle, so the
            // same load is not detected twice.
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_RELOAD;
            end
          end
        end

        // EX holds a bubble here, so branch and hazard inputs are ignored.
        LOAD_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end

        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (flush_event && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for idex_hazard_ctrl. Instance dut_a uses LOAD_LAT=1 and
// FLUSH_CYCLES=1. Instance dut_b uses LOAD_LAT=2, FLUSH_CYCLES=3 and a narrow
// counter width, so saturation is reachable in a short run. Both instances
// share the same inputs.
//
// The stimulus process drives the inputs just after a rising edge and pushes
// the expected results onto a queue. A monitor pops and compares those
// results on the following falling edge.
// -----------------------------------------------------------------------------
module tb_idex_hazard_ctrl;

  localparam int CNT_W_B = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, ex_branch_taken, mem_busy;

  logic              pc_a, ifw_a, idw_a, fl_a, bub_a;
  logic [1:0]        st_a;
  logic [15:0]       sc_a, fc_a;
  logic              pc_b, ifw_b, idw_b, fl_b, bub_b;
  logic [1:0]        st_b;
  logic [CNT_W_B-1:0] sc_b, fc_b;

  always #5 clk = ~clk;

  idex_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_a), .ifid_write(ifw_a), .idex_write(idw_a),
    .ifid_flush(fl_a), .idex_bubble(bub_a), .state(st_a),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  idex_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(3), .CNT_W(CNT_W_B)) dut_b (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_b), .ifid_write(ifw_b), .idex_write(idw_b),
    .ifid_flush(fl_b), .idex_bubble(bub_b), .state(st_b),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  // Output bundle order: {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble}
  localparam logic [4:0] O_IDLE   = 5'b11100;
  localparam logic [4:0] O_STALL  = 5'b00101;
  localparam logic [4:0] O_FLUSH  = 5'b11111;
  localparam logic [4:0] O_FROZEN = 5'b00000;

  typedef struct {
    string       name;
    bit          sel_b;
    logic [4:0]  outs;
    bit          chk_state;
    logic [1:0]  st;
    bit          chk_cnt;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, busy;
    logic [4:0] outs;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares queued expectations on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [4:0] o;
        e = sb_q.pop_front();
        o = e.sel_b ? {pc_b, ifw_b, idw_b, fl_b, bub_b} : {pc_a, ifw_a, idw_a, fl_a, bub_a};
        check({e.name, ".outs"}, 16'(o), 16'(e.outs));
        if (e.chk_state)
          check({e.name, ".state"}, 16'(e.sel_b ? st_b : st_a), 16'(e.st));
        if (e.chk_cnt) begin
          check({e.name, ".stall_count"}, e.sel_b ? 16'(sc_b) : sc_a, e.sc);
          check({e.name, ".flush_count"}, e.sel_b ? 16'(fc_b) : fc_a, e.fc);
        end
      end
    end
  end

  task automatic push(input string name, input bit sel_b, input logic [4:0] outs,
                      input bit chk_state, input logic [1:0] st,
                      input bit chk_cnt, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.name = name; e.sel_b = sel_b; e.outs = outs;
    e.chk_state = chk_state; e.st = st;
    e.chk_cnt = chk_cnt; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic br, input logic busy);
    ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs1 = u1; ifid_uses_rs2 = u2;
    idex_rd = rd; idex_mem_read = mr; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic idle_inputs();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    int stalls;
    int flushes;

    vecs[0]  = '{"haz_rs1",       5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, O_STALL};
    vecs[1]  = '{"idle_after",    5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE};
    vecs[2]  = '{"rd_zero",       5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, O_IDLE};
    vecs[3]  = '{"rs2_unused",    5'd1, 5'd7, 5'd7, 0, 0, 1, 0, 0, O_IDLE};
    vecs[4]  = '{"haz_rs2",       5'd1, 5'd7, 5'd7, 0, 1, 1, 0, 0, O_STALL};
    vecs[5]  = '{"no_memread",    5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 0, O_IDLE};
    vecs[6]  = '{"rs1_unused",    5'd9, 5'd2, 5'd9, 0, 1, 1, 0, 0, O_IDLE};
    vecs[7]  = '{"branch",        5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, O_FLUSH};
    vecs[8]  = '{"branch_haz",    5'd4, 5'd0, 5'd4, 1, 0, 1, 1, 0, O_FLUSH};
    vecs[9]  = '{"busy",          5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, O_FROZEN};
    vecs[10] = '{"busy_branch",   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, O_FROZEN};
    vecs[11] = '{"busy_haz",      5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 1, O_FROZEN};

    reset = 1'b1;
    idle_inputs();

    // Reset held for two cycles: idle outputs on both instances.
    for (int i = 0; i < 2; i++) begin
      step();
      push("in_reset_a", 0, O_IDLE, 0, 2'd0, 0, 16'd0, 16'd0);
      push("in_reset_b", 1, O_IDLE, 0, 2'd0, 0, 16'd0, 16'd0);
    end
    step();
    reset = 1'b0;
    push("post_reset_a", 0, O_IDLE, 1, 2'd0, 1, 16'd0, 16'd0);
    push("post_reset_b", 1, O_IDLE, 1, 2'd0, 1, 16'd0, 16'd0);

    // Table sweep on dut_a. The counters seen in each cycle reflect the
    // earlier rows only.
    stalls = 0;
    flushes = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].busy);
      push(vecs[i].name, 0, vecs[i].outs, 1, 2'd0, 1, 16'(stalls), 16'(flushes));
      if (vecs[i].outs[4] == 1'b0) stalls++;
      if (vecs[i].outs[1] == 1'b1) flushes++;
    end
    step();
    idle_inputs();
    push("table_totals", 0, O_IDLE, 1, 2'd0, 1, 16'(stalls), 16'(flushes));

    // Clear dut_b, which has been running through the table as well.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("b_clean", 1, O_IDLE, 1, 2'd0, 1, 16'd0, 16'd0);

    // Three-cycle flush; the second branch pulse during FLUSH is ignored.
    step(); drive(0, 0, 0, 0, 0, 0, 1, 0);
    push("fl_c0", 1, O_FLUSH, 1, 2'd0, 1, 16'd0, 16'd0);
    step(); drive(0, 0, 0, 0, 0, 0, 1, 0);
    push("fl_c1", 1, O_FLUSH, 1, 2'd2, 1, 16'd0, 16'd1);
    step(); idle_inputs();
    push("fl_c2", 1, O_FLUSH, 1, 2'd2, 0, 16'd0, 16'd0);
    step();
    push("fl_done", 1, O_IDLE, 1, 2'd0, 1, 16'd0, 16'd1);

    // Two-cycle load stall, frozen for 3 cycles by mem_busy in LOAD_STALL.
    step(); drive(5, 0, 1, 0, 5, 1, 0, 0);
    push("ls_c0", 1, O_STALL, 1, 2'd0, 0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(); drive(0, 0, 0, 0, 0, 0, 0, 1);
      push("ls_busy", 1, O_FROZEN, 1, 2'd1, 0, 16'd0, 16'd0);
    end
    // A branch during LOAD_STALL is ignored.
    step(); drive(0, 0, 0, 0, 0, 0, 1, 0);
    push("ls_release", 1, O_STALL, 1, 2'd1, 0, 16'd0, 16'd0);
    step(); idle_inputs();
    push("ls_done", 1, O_IDLE, 1, 2'd0, 1, 16'd5, 16'd1);

    // Branch and hazard together take the flush path; reset mid-flush.
    step(); drive(6, 0, 1, 0, 6, 1, 1, 0);
    push("bh_c0", 1, O_FLUSH, 1, 2'd0, 1, 16'd5, 16'd1);
    step(); idle_inputs();
    push("bh_c1", 1, O_FLUSH, 1, 2'd2, 1, 16'd5, 16'd2);
    step(); reset = 1'b1;
    push("mid_reset", 1, O_IDLE, 1, 2'd2, 0, 16'd0, 16'd0);
    step(); reset = 1'b0;
    push("after_reset", 1, O_IDLE, 1, 2'd0, 1, 16'd0, 16'd0);

    // stall_count saturates at 2^CNT_W-1 on dut_b.
    step(); drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (19) step();
    idle_inputs();
    push("saturate", 1, O_IDLE, 1, 2'd0, 1, 16'((1 << CNT_W_B) - 1), 16'd0);

    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
